rotation_decoder: RTL and testbench
===================================

Name: rotation_decoder

Overview:
- Inverse of the team's 4-bit shift/rotate datapath. Given an original word and a transformed word, it finds the shift or rotate amount and direction that produced the transformed word.
- Iterative search that tests one candidate amount per cycle, with a start/done handshake.
- Used by the self-check and debug logic next to the shifter, to recover sel_in/shift_dir from captured data.

Parameters:
- WIDTH, 4, data word width; must be >= 2.
- AMT_W, $clog2(WIDTH), width of the amount field (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  request pulse; accepted only in IDLE.
- orig_in  input  WIDTH  original word; latched when start is accepted.
- rot_in  input  WIDTH  transformed word; latched when start is accepted.
- op_in  input  1  0 = logical shift (zero fill), 1 = rotate; latched when start is accepted.
- busy_out  output  1  high in SEARCH and DONE.
- done_out  output  1  one-cycle pulse when a result is valid.
- found_out  output  1  1 = a matching amount exists.
- amt_out  output  AMT_W  recovered amount.
- dir_out  output  1  0 = left, 1 = right (same encoding as shift_dir).

Behaviour:
- Reset: state = IDLE. busy_out, done_out, found_out, amt_out and dir_out are all 0. Latched operands are cleared.
- Reset during SEARCH or DONE aborts the operation with no done pulse. Reset wins over a simultaneous start_in.
- States: IDLE, SEARCH, DONE.
- IDLE: when start_in=1, latch orig_in, rot_in and op_in, set k=0, go to SEARCH.
- SEARCH: each cycle compares the latched rot word against two candidates built from the latched orig word:
  - left by k (op=0: orig<<k; op=1: rotate left by k);
  - right by k (op=0: orig>>k; op=1: rotate right by k).
- Priority: smallest k wins. At equal k, left is checked before right, so k=0 always reports dir=0.
- On a match: register found=1, amt=k, dir, and go to DONE.
- No match and k=WIDTH-1: register found=0, amt=0, dir=0, and go to DONE.
- Otherwise k increments.
- DONE: done_out=1 for exactly one cycle, then go to IDLE.
- found_out, amt_out and dir_out hold their values until the next accepted start.
- Latency: start accepted at cycle T, match at k=j gives done_out at T+2+j. No match gives done_out at T+1+WIDTH.
- start_in while busy is ignored and not queued. Input changes after latching have no effect.
- Rotate ambiguity: right by k equals left by WIDTH-k. The priority rules above fix which one is reported.
- Logical-shift edge: a zero result matches the smallest k that clears all set bits. orig=rot=0 reports k=0, dir=0.

Optional Feature:
- ROT_DEC_PARALLEL_EN defined: all k and both directions are compared in the single SEARCH cycle. A priority encoder applies the same smallest-k, left-first order. done_out is always at T+2.
- Undefined: iterative search as above, with one candidate amount per cycle.
- Reported results are identical in both builds; only latency differs.

Decomposition:
- Package rot_dec_pkg contains:
  - state_t enum (IDLE, SEARCH, DONE);
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - OP_SHIFT=1'b0 and OP_ROTATE=1'b1.
- Sub-module word_shift_unit: combinational, parameterised by WIDTH.
  - Inputs: word, amount, direction, op. Output: the shifted or rotated word.
  - Instantiated twice (left and right) in the iterative build, or once per k per direction in the parallel build.

Test Plan:
- Rotate right: op=1, orig=1011, rot=1101, start at T -> done T+3, found=1, amt=1, dir=1.
- Shift left: op=0, orig=0110, rot=1100 -> done T+3, found=1, amt=1, dir=0.
- Ambiguous rotate: op=1, orig=1000, rot=0010 -> done T+4, found=1, amt=2, dir=0 (left preferred).
- Identity: op=1, orig=rot=1010 -> done T+2, found=1, amt=0, dir=0.
- No match: op=0, orig=0001, rot=0011 -> done T+5, found=0, amt=0, dir=0. Results hold until the next start.
- Control: start_in during SEARCH is ignored, with exactly one done pulse. Assert rst at T+2 of a search -> no done pulse, all outputs 0, and a new start at the next cycle works normally.

Source files
------------

// File: rtl/rotation_decoder_pkg.sv
// Shared definitions for the rotation decoder: FSM state encoding and the
// direction/operation encodings used by the companion shift/rotate datapath.
package rot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Direction encoding matches shift_dir on the shifter.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Operation encoding: logical shift fills with zeros, rotate wraps bits.
  localparam logic OP_SHIFT  = 1'b0;
  localparam logic OP_ROTATE = 1'b1;

endpackage

// File: rtl/rotation_decoder_word_shift_unit.sv
// word_shift_unit: combinational shift/rotate of one word by a given amount.
// Logical shifts fill with zeros; rotates OR in the bits pushed out of the
// opposite end. The amount is always below WIDTH, so the wrap shift by
// WIDTH-amount is at most WIDTH and collapses to zero for amount == 0.
module word_shift_unit
  import rot_dec_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] wrap;

  // Main shift plus the wrapped-around part, merged only for rotate.
  always_comb begin
    if (dir == DIR_RIGHT) begin
      fwd  = word >> amount;
      wrap = word << (WIDTH - int'(amount));
    end else begin
      fwd  = word << amount;
      wrap = word >> (WIDTH - int'(amount));
    end
    result = (op == OP_ROTATE) ? (fwd | wrap) : fwd;
  end

endmodule

// File: rtl/rotation_decoder.sv
// rotation_decoder: recovers the shift/rotate amount and direction that maps
// an original word onto a transformed word.
//
// Handshake: start_in is a request pulse that is accepted only while the
// decoder is idle (busy_out low); operands are captured on that edge and
// later input changes are ignored. busy_out stays high from the cycle after
// acceptance until the result cycle completes; done_out pulses for exactly
// one cycle and found_out/amt_out/dir_out are valid from that cycle on and
// hold until the next result is written. A start seen while busy is dropped.
//
// Build option: define ROT_DEC_PARALLEL_EN to evaluate every amount and both
// directions in a single search cycle. Without it, one amount is tested per
// cycle. Results are identical; only latency differs.
//
// Search order: smallest amount first, left before right at equal amount.
module rotation_decoder
  import rot_dec_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] orig_in,
  input  logic [WIDTH-1:0] rot_in,
  input  logic             op_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             found_out,
  output logic [AMT_W-1:0] amt_out,
  output logic             dir_out
);

  state_t           state;
  logic [WIDTH-1:0] orig_q;
  logic [WIDTH-1:0] rot_q;
  logic             op_q;
  logic [AMT_W-1:0] k;

  // Result of the current search cycle.
  logic             hit;
  logic [AMT_W-1:0] hit_amt;
  logic             hit_dir;
  logic             last;

`ifdef ROT_DEC_PARALLEL_EN

  logic [WIDTH-1:0] left_w  [WIDTH];
  logic [WIDTH-1:0] right_w [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_cand
    word_shift_unit #(.WIDTH(WIDTH)) u_left (
      .word   (orig_q),
      .amount (AMT_W'(g)),
      .dir    (DIR_LEFT),
      .op     (op_q),
      .result (left_w[g])
    );
    word_shift_unit #(.WIDTH(WIDTH)) u_right (
      .word   (orig_q),
      .amount (AMT_W'(g)),
      .dir    (DIR_RIGHT),
      .op     (op_q),
      .result (right_w[g])
    );
  end

  // Priority encoder: first hit in ascending amount, left before right.
  always_comb begin
    hit     = 1'b0;
    hit_amt = '0;
    hit_dir = DIR_LEFT;
    for (int i = 0; i < WIDTH; i++) begin
      if (!hit && (left_w[i] == rot_q)) begin
        hit     = 1'b1;
        hit_amt = AMT_W'(i);
        hit_dir = DIR_LEFT;
      end else if (!hit && (right_w[i] == rot_q)) begin
        hit     = 1'b1;
        hit_amt = AMT_W'(i);
        hit_dir = DIR_RIGHT;
      end
    end
  end

  // Every candidate is covered in one cycle, so the search always ends.
  assign last = 1'b1;

`else

  logic [WIDTH-1:0] left_w;
  logic [WIDTH-1:0] right_w;

  word_shift_unit #(.WIDTH(WIDTH)) u_left (
    .word   (orig_q),
    .amount (k),
    .dir    (DIR_LEFT),
    .op     (op_q),
    .result (left_w)
  );

  word_shift_unit #(.WIDTH(WIDTH)) u_right (
    .word   (orig_q),
    .amount (k),
    .dir    (DIR_RIGHT),
    .op     (op_q),
    .result (right_w)
  );

  // Test the current amount k; left wins when both directions match.
  always_comb begin
    hit     = (left_w == rot_q) || (right_w == rot_q);
    hit_amt = k;
    hit_dir = (left_w == rot_q) ? DIR_LEFT : DIR_RIGHT;
  end

  // The final amount has been tried once k reaches WIDTH-1.
  assign last = (k == AMT_W'(WIDTH - 1));

`endif

  // Control FSM: capture operands, step the search, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      found_out <= 1'b0;
      amt_out   <= '0;
      dir_out   <= DIR_LEFT;
      orig_q    <= '0;
      rot_q     <= '0;
      op_q      <= OP_SHIFT;
      k         <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            orig_q   <= orig_in;
            rot_q    <= rot_in;
            op_q     <= op_in;
            k        <= '0;
            busy_out <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            found_out <= 1'b1;
            amt_out   <= hit_amt;
            dir_out   <= hit_dir;
            done_out  <= 1'b1;
            state     <= DONE;
          end else if (last) begin
            found_out <= 1'b0;
            amt_out   <= '0;
            dir_out   <= DIR_LEFT;
            done_out  <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + AMT_W'(1);
          end
        end
        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_decoder.sv
// Self-checking bench for rotation_decoder: directed cases, reset/abort
// control cases, and randomized operand pairs scored against a reference
// model built from repeated single-bit arithmetic shifts.
module tb_rotation_decoder;
  import rot_dec_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam int M  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [W-1:0]  orig_in;
  logic [W-1:0]  rot_in;
  logic          op_in;
  logic          busy_out;
  logic          done_out;
  logic          found_out;
  logic [AW-1:0] amt_out;
  logic          dir_out;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Expected {found, amt, dir} per issued operation.
  logic [AW+1:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  rotation_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .orig_in   (orig_in),
    .rot_in    (rot_in),
    .op_in     (op_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .found_out (found_out),
    .amt_out   (amt_out),
    .dir_out   (dir_out)
  );

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) if (done_out === 1'b1) done_cnt++;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Apply k single-bit steps using multiply/divide on integers.
  function automatic int xform(input int x, input int k, input bit right, input bit rot);
    int y = x;
    for (int i = 0; i < k; i++) begin
      if (!right) y = ((y * 2) % M) + (rot ? (y / (M / 2)) : 0);
      else        y = (y / 2) + (rot ? ((y % 2) * (M / 2)) : 0);
    end
    return y;
  endfunction

  task automatic model(input int o, input int r, input bit op,
                       output bit f, output int a, output bit d);
    f = 1'b0; a = 0; d = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (!f && xform(o, k, 1'b0, op) == r) begin f = 1'b1; a = k; d = 1'b0; end
      else if (!f && xform(o, k, 1'b1, op) == r) begin f = 1'b1; a = k; d = 1'b1; end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Optionally pulses a stray start
  // during the search and scrambles the inputs after capture.
  task automatic run_op(input logic [W-1:0] o, input logic [W-1:0] r,
                        input logic op, input bit stray);
    bit f; int a; bit d; int lat; int cyc; int base;
    logic [AW+1:0] e;
    model(int'(o), int'(r), op, f, a, d);
    exp_q.push_back({f, AW'(a), d});
`ifdef ROT_DEC_PARALLEL_EN
    lat = 2;
`else
    lat = f ? 2 + a : 1 + W;
`endif
    base = done_cnt;
    orig_in = o; rot_in = r; op_in = op; start_in = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_search", busy_out, 1);
        start_in = stray;
        orig_in  = ~o;
        rot_in   = W'($urandom);
        op_in    = ~op;
      end else begin
        start_in = 1'b0;
      end
    end while (done_out !== 1'b1 && cyc < 40);
    start_in = 1'b0;
    check("done_seen", done_out, 1);
    check("latency", cyc, lat);
    e = exp_q.pop_front();
    check("found", found_out, e[AW+1]);
    check("amt", amt_out, e[AW:1]);
    check("dir", dir_out, e[0]);
    check("busy_done", busy_out, 1);
    @(negedge clk);
    check("done_width", done_out, 0);
    check("busy_idle", busy_out, 0);
    repeat (2) @(negedge clk);
    check("done_count", done_cnt - base, 1);
    check("hold_found", found_out, e[AW+1]);
    check("hold_amt", amt_out, e[AW:1]);
    check("hold_dir", dir_out, e[0]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [W-1:0] o, r;
    logic op;
    rst = 1'b1; start_in = 1'b0; orig_in = '0; rot_in = '0; op_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_found", found_out, 0);
    check("rst_amt", amt_out, 0);
    check("rst_dir", dir_out, 0);
    rst = 1'b0;

    // Directed cases
    run_op(4'b1011, 4'b1101, 1'b1, 1'b0);  // rotate right by 1
    run_op(4'b0110, 4'b1100, 1'b0, 1'b1);  // shift left by 1, stray start
    run_op(4'b1000, 4'b0010, 1'b1, 1'b0);  // ambiguous rotate, left wins
    run_op(4'b1010, 4'b1010, 1'b1, 1'b1);  // identity
    run_op(4'b0001, 4'b0011, 1'b0, 1'b1);  // no match
    run_op(4'b0000, 4'b0000, 1'b0, 1'b0);  // zero to zero
    run_op(4'b0100, 4'b0000, 1'b0, 1'b0);  // zero result, smallest clearing k
    run_op(4'b1001, 4'b0011, 1'b1, 1'b0);  // rotate left by 1 (right by 3)

    // Reset during search aborts with no done pulse
    run_op(4'b1000, 4'b0010, 1'b1, 1'b0);
    base = done_cnt;
    orig_in = 4'b0001; rot_in = 4'b0011; op_in = 1'b0; start_in = 1'b1;
    @(posedge clk);
    @(negedge clk); start_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_out, 0);
    check("abort_done", done_out, 0);
    check("abort_found", found_out, 0);
    check("abort_amt", amt_out, 0);
    check("abort_dir", dir_out, 0);
    check("abort_no_pulse", done_cnt - base, 0);
    rst = 1'b0;
    run_op(4'b1011, 4'b1101, 1'b1, 1'b0);

    // Reset wins over a simultaneous start
    rst = 1'b1; start_in = 1'b1; orig_in = 4'b0011; rot_in = 4'b0110; op_in = 1'b0;
    @(negedge clk);
    check("rst_vs_start_busy", busy_out, 0);
    rst = 1'b0; start_in = 1'b0;
    @(negedge clk);
    check("rst_vs_start_idle", busy_out, 0);

    // Randomized operand pairs
    for (int n = 0; n < 40; n++) begin
      o  = W'($urandom);
      op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        r = W'(xform(int'(o), $urandom_range(0, W - 1), 1'($urandom_range(0, 1)), op));
      else
        r = W'($urandom);
      run_op(o, r, op, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
